// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Sequences bytes from the UART byte receiver into validated frames of the
// form header, length, payload[length], checksum (XOR of length and payload).
// A completed frame is held on the outputs until the consumer acknowledges it.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for the header byte; other bytes are discarded
// S_LEN     | header seen, waiting for the payload length byte
// S_PAYLOAD | collecting payload bytes into the buffer
// S_CHECK   | waiting for the checksum byte
// S_HOLD    | frame presented with frame_valid until frame_ack
module uart_rx_frame_ctrl #(
   parameter int          MAX_LEN = 8,
   parameter logic [7:0]  HEADER  = 8'hA5,
   parameter logic [15:0] TIMEOUT = 16'd20000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           rx_data,
   input  logic                 rx_done,
   output logic [8*MAX_LEN-1:0] frame_data,
   output logic [3:0]           frame_len,
   output logic                 frame_valid,
   input  logic                 frame_ack,
   output logic                 frame_err,
   output logic [1:0]           err_code,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_CHECK,
      S_HOLD
   } state_t;

   localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

   localparam logic [1:0] ERR_OVERRUN = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_CHK     = 2'd2;
   localparam logic [1:0] ERR_TMO     = 2'd3;

   state_t                 r_state;
   logic                   r_rx_done_q;
   logic [3:0]             r_len;
   logic [3:0]             r_idx;
   logic [7:0]             r_chk;
   logic [15:0]            r_tmo;
   logic [8*MAX_LEN-1:0]   r_buf;
   logic [3:0]             r_frame_len;
   logic                   r_frame_valid;
   logic                   r_frame_err;
   logic [1:0]             r_err_code;
   logic                   r_busy;

   logic                   w_strobe;
   logic                   w_len_ok;
   logic                   w_tmo_hit;
   logic                   w_abort;
   logic                   w_ovr;
   logic [1:0]             w_err_code;

   assign w_strobe  = rx_done & ~r_rx_done_q;
   assign w_len_ok  = (rx_data != 8'd0) && (rx_data <= LEN_MAX);
   assign w_tmo_hit = (r_tmo == TIMEOUT - 16'd1);

   assign frame_data  = r_buf;
   assign frame_len   = r_frame_len;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign err_code    = r_err_code;
   assign busy        = r_busy;

   // Edge detect on rx_done; reset to 1 so a level already high is not a byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rx_done_q <= 1'b1;
      else        r_rx_done_q <= rx_done;
   end

   // Classify this cycle's error: aborts return to idle, overrun keeps the frame.
   always_comb begin
      w_abort    = 1'b0;
      w_ovr      = 1'b0;
      w_err_code = ERR_OVERRUN;
      case (r_state)
         S_LEN: begin
            if (w_strobe && !w_len_ok) begin
               w_abort    = 1'b1;
               w_err_code = ERR_LEN;
            end else if (!w_strobe && w_tmo_hit) begin
               w_abort    = 1'b1;
               w_err_code = ERR_TMO;
            end
         end
         S_PAYLOAD: begin
            if (!w_strobe && w_tmo_hit) begin
               w_abort    = 1'b1;
               w_err_code = ERR_TMO;
            end
         end
         S_CHECK: begin
            if (w_strobe && (rx_data != r_chk)) begin
               w_abort    = 1'b1;
               w_err_code = ERR_CHK;
            end else if (!w_strobe && w_tmo_hit) begin
               w_abort    = 1'b1;
               w_err_code = ERR_TMO;
            end
         end
         S_HOLD: begin
            if (w_strobe && !frame_ack) begin
               w_ovr      = 1'b1;
               w_err_code = ERR_OVERRUN;
            end
         end
         default: ;
      endcase
   end

   // Frame FSM with registered outputs, timeout counter and payload buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_len         <= 4'd0;
         r_idx         <= 4'd0;
         r_chk         <= 8'd0;
         r_tmo         <= 16'd0;
         r_buf         <= '0;
         r_frame_len   <= 4'd0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_err_code    <= 2'd0;
         r_busy        <= 1'b0;
      end else begin
         r_frame_err <= w_abort | w_ovr;
         if (w_abort | w_ovr) r_err_code <= w_err_code;

         if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_buf   <= '0;
            r_idx   <= 4'd0;
            r_tmo   <= 16'd0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_tmo <= 16'd0;
                  if (w_strobe && (rx_data == HEADER)) begin
                     r_state <= S_LEN;
                     r_busy  <= 1'b1;
                     r_buf   <= '0;
                  end
               end
               S_LEN: begin
                  if (w_strobe) begin
                     r_len   <= rx_data[3:0];
                     r_chk   <= rx_data;
                     r_idx   <= 4'd0;
                     r_tmo   <= 16'd0;
                     r_state <= S_PAYLOAD;
                  end else begin
                     r_tmo <= r_tmo + 16'd1;
                  end
               end
               S_PAYLOAD: begin
                  if (w_strobe) begin
                     for (int i = 0; i < MAX_LEN; i++) begin
                        if (r_idx == 4'(i)) r_buf[8*i +: 8] <= rx_data;
                     end
                     r_chk <= r_chk ^ rx_data;
                     r_idx <= r_idx + 4'd1;
                     r_tmo <= 16'd0;
                     if (r_idx == r_len - 4'd1) r_state <= S_CHECK;
                  end else begin
                     r_tmo <= r_tmo + 16'd1;
                  end
               end
               S_CHECK: begin
                  if (w_strobe) begin
                     r_state       <= S_HOLD;
                     r_frame_valid <= 1'b1;
                     r_frame_len   <= r_len;
                     r_tmo         <= 16'd0;
                  end else begin
                     r_tmo <= r_tmo + 16'd1;
                  end
               end
               S_HOLD: begin
                  r_tmo <= 16'd0;
                  if (frame_ack) begin
                     r_frame_valid <= 1'b0;
                     if (w_strobe && (rx_data == HEADER)) begin
                        r_state <= S_LEN;
                        r_busy  <= 1'b1;
                        r_buf   <= '0;
                        r_idx   <= 4'd0;
                     end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with hand-computed expectations.
module tb_uart_rx_frame_ctrl;

   localparam int          MAX_LEN = 8;
   localparam logic [15:0] TMO     = 16'd100;

   logic                 clk;
   logic                 rst_n;
   logic [7:0]           rx_data;
   logic                 rx_done;
   logic [8*MAX_LEN-1:0] frame_data;
   logic [3:0]           frame_len;
   logic                 frame_valid;
   logic                 frame_ack;
   logic                 frame_err;
   logic [1:0]           err_code;
   logic                 busy;

   int n_checks = 0;
   int n_errors = 0;

   uart_rx_frame_ctrl #(
      .MAX_LEN (MAX_LEN),
      .HEADER  (8'hA5),
      .TIMEOUT (TMO)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .frame_data  (frame_data),
      .frame_len   (frame_len),
      .frame_valid (frame_valid),
      .frame_ack   (frame_ack),
      .frame_err   (frame_err),
      .err_code    (err_code),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // Drop rx_done for a cycle then raise it; returns #1 after the strobe edge.
   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_done = 1'b0;
      rx_data = b;
      @(posedge clk); #1;
      rx_done = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic ack_frame();
      @(posedge clk); #1;
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      rx_done   = 1'b1;
      rx_data   = 8'hA5;
      frame_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_valid", {63'd0, frame_valid}, 64'd0);
      check_val("rst_busy",  {63'd0, busy},        64'd0);
      check_val("rst_err",   {63'd0, frame_err},   64'd0);
      check_val("rst_code",  {62'd0, err_code},    64'd0);
      check_val("rst_len",   {60'd0, frame_len},   64'd0);
      check_val("rst_data",  frame_data,           64'd0);
      #2 rst_n = 1'b1;

      // rx_done already high at reset release must not count as a header
      repeat (3) @(posedge clk);
      #1;
      check_val("rel_no_byte", {63'd0, busy}, 64'd0);

      // Valid 3-byte frame
      send_byte(8'hA5);
      check_val("hdr_busy", {63'd0, busy}, 64'd1);
      send_byte(8'h03);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      check_val("pre_chk_valid", {63'd0, frame_valid}, 64'd0);
      send_byte(8'h03);
      check_val("f1_valid", {63'd0, frame_valid}, 64'd1);
      check_val("f1_len",   {60'd0, frame_len},   64'd3);
      check_val("f1_data",  frame_data,           64'h332211);
      repeat (5) @(posedge clk);
      #1;
      check_val("f1_hold_valid", {63'd0, frame_valid}, 64'd1);
      check_val("f1_hold_data",  frame_data,           64'h332211);
      check_val("f1_hold_len",   {60'd0, frame_len},   64'd3);
      ack_frame();
      check_val("f1_ack_valid", {63'd0, frame_valid}, 64'd0);
      check_val("f1_ack_busy",  {63'd0, busy},        64'd0);

      // Length 0 and length above MAX_LEN
      send_byte(8'hA5);
      send_byte(8'h00);
      check_val("len0_err",  {63'd0, frame_err}, 64'd1);
      check_val("len0_code", {62'd0, err_code},  64'd1);
      check_val("len0_busy", {63'd0, busy},      64'd0);
      @(posedge clk); #1;
      check_val("len0_pulse_end", {63'd0, frame_err}, 64'd0);
      send_byte(8'hA5);
      send_byte(8'h09);
      check_val("len9_err",  {63'd0, frame_err}, 64'd1);
      check_val("len9_code", {62'd0, err_code},  64'd1);

      // Length MAX_LEN is accepted: A5,08 leaves the controller busy
      send_byte(8'hA5);
      send_byte(8'h08);
      check_val("len8_noerr", {63'd0, frame_err}, 64'd0);
      check_val("len8_busy",  {63'd0, busy},      64'd1);
      // abandon it by timeout (last strobe edge just passed)
      repeat (TMO) @(posedge clk);
      #1;
      check_val("len8_tmo_code", {62'd0, err_code}, 64'd3);
      check_val("len8_tmo_busy", {63'd0, busy},     64'd0);

      // Checksum error: expected 01^7E = 7F
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h7E);
      send_byte(8'h00);
      check_val("chk_err",   {63'd0, frame_err},   64'd1);
      check_val("chk_code",  {62'd0, err_code},    64'd2);
      check_val("chk_valid", {63'd0, frame_valid}, 64'd0);

      // Timeout in PAYLOAD: error exactly TMO cycles after the last strobe edge
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h10);
      repeat (TMO - 1) @(posedge clk);
      #1;
      check_val("tmo_early_err",  {63'd0, frame_err}, 64'd0);
      check_val("tmo_early_busy", {63'd0, busy},      64'd1);
      @(posedge clk); #1;
      check_val("tmo_err",  {63'd0, frame_err}, 64'd1);
      check_val("tmo_code", {62'd0, err_code},  64'd3);
      check_val("tmo_busy", {63'd0, busy},      64'd0);
      check_val("tmo_data", frame_data,         64'd0);

      // Following frame A5,01,44,45 with zeroed upper bytes
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h44);
      send_byte(8'h45);
      check_val("f2_valid", {63'd0, frame_valid}, 64'd1);
      check_val("f2_len",   {60'd0, frame_len},   64'd1);
      check_val("f2_data",  frame_data,           64'h44);

      // Overrun while holding unacked
      send_byte(8'h55);
      check_val("ovr_err",   {63'd0, frame_err},   64'd1);
      check_val("ovr_code",  {62'd0, err_code},    64'd0);
      check_val("ovr_valid", {63'd0, frame_valid}, 64'd1);
      check_val("ovr_data",  frame_data,           64'h44);
      check_val("ovr_len",   {60'd0, frame_len},   64'd1);

      // Ack coincident with a header byte goes straight to LEN
      @(posedge clk); #1;
      rx_done = 1'b0;
      rx_data = 8'hA5;
      @(posedge clk); #1;
      rx_done   = 1'b1;
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
      check_val("ackhdr_busy",  {63'd0, busy},        64'd1);
      check_val("ackhdr_valid", {63'd0, frame_valid}, 64'd0);
      check_val("ackhdr_err",   {63'd0, frame_err},   64'd0);
      send_byte(8'h01);
      send_byte(8'h66);
      send_byte(8'h67);
      check_val("f3_valid", {63'd0, frame_valid}, 64'd1);
      check_val("f3_data",  frame_data,           64'h66);
      ack_frame();

      // Asynchronous reset mid-PAYLOAD
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h11);
      check_val("mid_data", frame_data,    64'h11);
      check_val("mid_busy", {63'd0, busy}, 64'd1);
      #3 rst_n = 1'b0;
      #1;
      check_val("arst_busy",  {63'd0, busy},        64'd0);
      check_val("arst_data",  frame_data,           64'd0);
      check_val("arst_len",   {60'd0, frame_len},   64'd0);
      check_val("arst_valid", {63'd0, frame_valid}, 64'd0);
      check_val("arst_err",   {63'd0, frame_err},   64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
